dt_pack: RTL and testbench
==========================

Name: dt_pack

Overview:
- Reverse direction of the distance-transform datapath.
- Reads the 128x128 byte-per-pixel result memory, thresholds each pixel to one bit, and packs 16 pixels per word, MSB-first.
- Writes the packed words into a 1024x16 binary-image memory with the same layout the distance transform reads: word w, bit 15-k = pixel 16w+k.
- Used to regenerate binary masks (e.g. "distance >= N") and to loop-back-check the transform.

Parameters:
- THRESH, 1, pixel maps to 1 iff res_di >= THRESH (unsigned 8-bit compare).
- NPIX, 16384, pixel count; must be a multiple of 16; word count = NPIX/16.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- start  input  1  one-cycle request to begin a pack pass
- busy  output  1  high while a pass is in progress
- done  output  1  level; high after a pass completes, until next start or reset
- res_rd  output  1  read strobe to result memory
- res_addr  output  14  pixel address, row-major (row*128+col)
- res_di  input  8  pixel data, one-cycle read latency
- sti_wr  output  1  one-cycle write strobe to binary-image memory
- sti_addr  output  10  word address
- sti_do  output  16  packed word

Behaviour:
- Reset values (reset=0 at a rising edge): state IDLE; busy=0, done=0, res_rd=0, res_addr=0, sti_wr=0, sti_addr=0, sti_do=0; shift register and bit counter cleared.
- Reset mid-pass aborts immediately. No further writes occur. A word partially shifted is discarded.
- Read latency: res_di sampled at edge E is the data for the res_addr value driven during the cycle before E.
- States: IDLE, RUN, DONE.
- IDLE / DONE, start=1 at edge T0:
  - res_rd<=1, res_addr<=0, busy<=1, done<=0, bitcnt<=0, state<=RUN.
  - start=0 in these states: outputs hold.
- RUN, edge T(k+1), k=0..NPIX-1:
  - bit = (res_di >= THRESH); shift <= {shift[14:0], bit}; bitcnt <= bitcnt+1 (4-bit, wraps).
  - res_addr <= res_addr+1, saturating at NPIX-1 (no wrap to 0).
- Word emit: at an edge where bitcnt==15 (16th bit captured):
  - sti_do <= {shift[14:0], bit}, sti_wr <= 1, sti_addr <= word index k>>4.
  - sti_wr is 0 at every other edge, so each strobe is exactly one cycle and write addresses are strictly 0,1,...,NPIX/16-1.
  - First write is visible in the cycle after T16, with sti_addr=0.
- Last pixel (k=NPIX-1, edge T(NPIX)):
  - The final word is emitted at this edge.
  - Same edge: res_rd<=0, busy<=0, done<=1, state<=DONE.
  - Total pass = NPIX+1 cycles from the start edge; exactly NPIX reads and NPIX/16 writes.
- start while in RUN is ignored; it has no effect on address, counters or outputs.
- sti_do and sti_addr hold their last values between strobes and after done.
- No backpressure: the memories accept one access per cycle.
- Compare is unsigned over the full 8 bits. THRESH=0 forces all bits to 1.

Test Plan:
- All-zero result memory, THRESH=1, start pulse -> 1024 writes, addresses 0..1023 in order, every sti_do=16'h0000; done rises at cycle 16385 after start; busy falls in the same cycle.
- All bytes = 8'd5, THRESH=5 -> every word 16'hFFFF. Same data with THRESH=6 -> every word 16'h0000.
- Pixel 0 = 1, pixels 1..15 = 0, pixel 16383 = 1, rest 0 -> word 0 = 16'h8000, word 1023 = 16'h0001, all others 16'h0000 (checks MSB-first order and last-word flush).
- Column-alternating pattern (even col = 3, odd col = 0), THRESH=1 -> every word 16'hAAAA. Check res_addr never exceeds 16383 and res_rd=0 after done.
- Assert reset=0 one cycle after the 40th pixel read -> next cycle all outputs at reset values; exactly 2 writes (addr 0,1) total. A subsequent start performs a full clean pass.
- Pulse start at cycles 100 and 5000 of a pass -> no restart, write sequence unchanged. Start again while done=1 -> done drops at that edge and a second identical pass runs.

Source files
------------

// File: rtl/dt_pack.sv
// Packs the byte-per-pixel result memory into a 1-bit-per-pixel image memory,
// 16 pixels per word, MSB-first (word w, bit 15-k = pixel 16w+k).
module dt_pack #(
    parameter logic [7:0] THRESH = 8'd1,
    parameter int         NPIX   = 16384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        res_rd,
    output logic [13:0] res_addr,
    input  logic [7:0]  res_di,
    output logic        sti_wr,
    output logic [9:0]  sti_addr,
    output logic [15:0] sti_do
);

    localparam logic [13:0] LAST = 14'(NPIX - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [14:0] shift;
    logic [3:0]  bitcnt;
    logic        bit_in;

    assign bit_in = (res_di >= THRESH);

    // res_addr holds the address of the pixel arriving on res_di at each RUN
    // edge, so it doubles as the pixel index: no separate pixel counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            res_rd   <= 1'b0;
            res_addr <= '0;
            sti_wr   <= 1'b0;
            sti_addr <= '0;
            sti_do   <= '0;
            shift    <= '0;
            bitcnt   <= '0;
        end else begin
            sti_wr <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        res_rd   <= 1'b1;
                        res_addr <= '0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        bitcnt   <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    shift  <= {shift[13:0], bit_in};
                    bitcnt <= bitcnt + 4'd1;
                    if (res_addr != LAST)
                        res_addr <= res_addr + 14'd1;
                    if (bitcnt == 4'd15) begin
                        sti_do   <= {shift, bit_in};
                        sti_wr   <= 1'b1;
                        sti_addr <= res_addr[13:4];
                    end
                    if (res_addr == LAST) begin
                        res_rd <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dt_pack.sv
// Scoreboard bench for dt_pack: a full-size instance (THRESH=1) and a small
// instance (THRESH=5, NPIX=256), each fed by a behavioural memory model.
module tb_dt_pack;

    localparam int NPIX  = 16384;
    localparam int NPIX2 = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, start2;
    logic        busy, done, res_rd, sti_wr;
    logic [13:0] res_addr;
    logic [7:0]  res_di;
    logic [9:0]  sti_addr;
    logic [15:0] sti_do;
    logic        busy2, done2, res_rd2, sti_wr2;
    logic [13:0] res_addr2;
    logic [7:0]  res_di2;
    logic [9:0]  sti_addr2;
    logic [15:0] sti_do2;

    logic [7:0]  mem  [0:NPIX-1];
    logic [7:0]  mem2 [0:NPIX2-1];
    logic [25:0] q[$];
    logic [25:0] q2[$];

    int checks = 0;
    int errors = 0;
    int reads  = 0;
    int writes = 0;

    always #5 clk = ~clk;

    dt_pack #(.THRESH(8'd1), .NPIX(NPIX)) u_dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .res_rd(res_rd), .res_addr(res_addr), .res_di(res_di),
        .sti_wr(sti_wr), .sti_addr(sti_addr), .sti_do(sti_do)
    );

    dt_pack #(.THRESH(8'd5), .NPIX(NPIX2)) u_small (
        .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2),
        .res_rd(res_rd2), .res_addr(res_addr2), .res_di(res_di2),
        .sti_wr(sti_wr2), .sti_addr(sti_addr2), .sti_do(sti_do2)
    );

    // Memory presents the addressed byte; the DUT samples it at the next edge.
    always_comb res_di  = mem[res_addr];
    always_comb res_di2 = mem2[res_addr2[7:0]];

    always @(negedge clk) begin
        if (sti_wr) begin
            writes++;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL sti_unexpected got addr=%0d data=%h expected no write", sti_addr, sti_do);
            end else begin
                logic [25:0] e;
                e = q.pop_front();
                if ({sti_addr, sti_do} !== e) begin
                    errors++;
                    $display("FAIL sti_word got addr=%0d data=%h expected addr=%0d data=%h",
                             sti_addr, sti_do, e[25:16], e[15:0]);
                end
            end
        end
        if (res_rd) reads++;
    end

    always @(negedge clk) begin
        if (sti_wr2) begin
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL small_unexpected got addr=%0d data=%h expected no write", sti_addr2, sti_do2);
            end else begin
                logic [25:0] e;
                e = q2.pop_front();
                if ({sti_addr2, sti_do2} !== e) begin
                    errors++;
                    $display("FAIL small_word got addr=%0d data=%h expected addr=%0d data=%h",
                             sti_addr2, sti_do2, e[25:16], e[15:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Reference: word w collects pixels 16w..16w+15, first pixel in bit 15.
    task automatic push_exp(input int nw);
        for (int w = 0; w < nw; w++) begin
            logic [15:0] word;
            word = '0;
            for (int k = 0; k < 16; k++)
                if (mem[16*w + k] >= 8'd1) word[15-k] = 1'b1;
            q.push_back({10'(w), word});
        end
    endtask

    task automatic push_exp2();
        for (int w = 0; w < NPIX2/16; w++) begin
            logic [15:0] word;
            word = '0;
            for (int k = 0; k < 16; k++)
                if (mem2[16*w + k] >= 8'd5) word[15-k] = 1'b1;
            q2.push_back({10'(w), word});
        end
    endtask

    task automatic run_pass(input bit inject);
        int cyc;
        reads = 0;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("done_after_start", done, 0);
        cyc = 0;
        while (!done && cyc < NPIX + 100) begin
            if (inject && (cyc == 100 || cyc == 5000)) start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            cyc++;
        end
        chk("done_latency", cyc, NPIX);
        chk("busy_at_done", busy, 0);
        chk("res_rd_at_done", res_rd, 0);
        chk("res_addr_saturated", res_addr, NPIX - 1);
        @(negedge clk); #1;
        chk("read_count", reads, NPIX);
        chk("queue_empty", q.size(), 0);
        chk("sti_addr_hold", sti_addr, NPIX/16 - 1);
    endtask

    task automatic run_small();
        int cyc;
        push_exp2();
        start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        cyc = 0;
        while (!done2 && cyc < NPIX2 + 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("small_done_latency", cyc, NPIX2);
        @(negedge clk); #1;
        chk("small_queue_empty", q2.size(), 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_res_rd"}, res_rd, 0);
        chk({tag, "_res_addr"}, res_addr, 0);
        chk({tag, "_sti_wr"}, sti_wr, 0);
        chk({tag, "_sti_addr"}, sti_addr, 0);
        chk({tag, "_sti_do"}, sti_do, 0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; start2 = 1'b0;
        for (int i = 0; i < NPIX; i++) mem[i] = 8'd0;
        for (int i = 0; i < NPIX2; i++) mem2[i] = 8'd0;
        repeat (3) @(posedge clk);
        #1 chk_reset_vals("reset");
        reset = 1'b1;
        @(posedge clk); #1;

        // Sparse pattern: first and last pixel set, exercises bit order and last-word flush.
        mem[0] = 8'd1; mem[NPIX-1] = 8'd1;
        push_exp(NPIX/16);
        run_pass(1'b0);

        // Random data with mid-pass start pulses, then a restart while done.
        for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom_range(0, 3));
        push_exp(NPIX/16);
        run_pass(1'b1);
        repeat (3) @(posedge clk); #1;
        push_exp(NPIX/16);
        run_pass(1'b0);

        // Abort after the 40th read: only words 0 and 1 may be written.
        writes = 0;
        push_exp(2);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (40) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        chk_reset_vals("abort");
        reset = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("abort_writes", writes, 2);
        chk("abort_queue_empty", q.size(), 0);
        chk("abort_idle_busy", busy, 0);

        // Column-alternating pattern after the abort: clean full pass.
        for (int i = 0; i < NPIX; i++) mem[i] = ((i % 128) % 2 == 0) ? 8'd3 : 8'd0;
        writes = 0;
        push_exp(NPIX/16);
        run_pass(1'b0);
        chk("alt_writes", writes, NPIX/16);

        // Small instance, THRESH=5: equality boundary, just-below, random.
        for (int i = 0; i < NPIX2; i++) mem2[i] = 8'd5;
        run_small();
        for (int i = 0; i < NPIX2; i++) mem2[i] = 8'd4;
        run_small();
        for (int i = 0; i < NPIX2; i++) mem2[i] = 8'($urandom_range(0, 10));
        run_small();
        for (int i = 0; i < NPIX2; i++) mem2[i] = 8'($urandom_range(200, 255));
        run_small();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
